mdu_scheduler: RTL and testbench
================================

Name: mdu_scheduler

Overview:
- Multi-cycle multiply/divide unit controller for the E stage of the 5-stage pipeline.
- Accepts one mult/multu/div/divu per start pulse and sequences a fixed-latency busy window.
- Commits the result to the HI/LO registers at the end of that window and serves mfhi/mflo/mthi/mtlo.
- Raises a stall request to the Delay hazard unit while a later MD-class instruction in D would collide with a running operation.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1)

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  E-stage instruction is mult/multu/div/divu and is valid (not a cleared bubble)
- MDU_Op  input  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others none
- SrcA  input  32  forwarded rs value (E_RD1_FW)
- SrcB  input  32  forwarded rt value (E_RD2_FW)
- D_Is_MD  input  1  D-stage instruction is any of ops 1–8
- busy  output  1  operation in progress
- HI  output  32  HI register
- LO  output  32  LO register
- MDU_Result  output  32  combinational: HI when MDU_Op=5, LO when MDU_Op=6, else 0
- MD_Stall  output  1  combinational: D_Is_MD & (start | busy)

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - state=IDLE, busy=0, counter=0, HI=0, LO=0, pending results=0.
  - Any in-flight operation is discarded.
- States: IDLE, BUSY. Counter width is ceil(log2(max(MULT_CYCLES,DIV_CYCLES)+1)).
- IDLE, start=1, MDU_Op in 1–4, at edge k:
  - Compute the full result from SrcA/SrcB and latch it into pending HI/LO registers.
  - Load counter with MULT_CYCLES (ops 1–2) or DIV_CYCLES (ops 3–4); go to BUSY.
  - busy rises at edge k.
- BUSY:
  - Counter decrements every edge.
  - At the edge where counter goes 1→0: HI/LO take the pending values, state=IDLE, busy=0.
  - busy is therefore high for exactly N cycles after the start edge.
  - A fresh start may be accepted on the first cycle busy=0.
- start asserted while in BUSY: ignored. The hazard unit guarantees it cannot occur; the bench flags it as a protocol error.
- start=1 with MDU_Op outside 1–4: ignored.
- mult: {HI,LO} = $signed(SrcA) * $signed(SrcB), 64-bit.
- multu: {HI,LO} = unsigned 64-bit product.
- div:
  - LO = signed quotient, truncated toward zero; HI = remainder, sign follows the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: LO = unsigned quotient, HI = unsigned remainder.
- Divisor = 0 (div or divu):
  - The full DIV_CYCLES busy window still runs.
  - HI/LO are left unchanged at commit.
- mthi/mtlo (MDU_Op 7/8):
  - Write SrcA into HI/LO at the edge, only when state=IDLE and start=0; otherwise ignored.
  - MD_Stall keeps them out of E while busy.
- mfhi/mflo (MDU_Op 5/6): MDU_Result reflects the current register value, with no bypass from the pending registers.
- Stalls:
  - MD_Stall depends only on current inputs and state, with no registered delay.
  - It is ORed into the Delay Stall, so D is held until busy=0 and no start is in E.
- Pipeline flush of E (D_E_clear) arrives as start=0. An operation already in BUSY always completes.

Test Plan:
- mult SrcA=0xFFFFFFFD (−3), SrcB=5, start pulse: busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1; HI/LO unchanged during busy.
- divu 7/2: busy for 10 cycles, then LO=3, HI=1. div 0xFFFFFFF9 (−7)/2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- Preload HI=0x11, LO=0x22 via mthi/mtlo, then div by 0: busy for 10 cycles, then HI=0x11, LO=0x22; mfhi gives MDU_Result=0x11.
- D_Is_MD=1 held across start plus the busy window: MD_Stall=1 on the start cycle and all 5 (mult) busy cycles, 0 on the cycle after busy falls; D_Is_MD=0 keeps MD_Stall=0 throughout.
- Assert reset on busy cycle 3 of a multu 0xFFFFFFFF*0xFFFFFFFF: busy, HI and LO drop to 0 immediately, without waiting for a clock edge; after release with no start, HI/LO stay 0.
- Back-to-back: mult on the first cycle busy=0 after a previous div → accepted. mthi issued while busy → HI unchanged.

Source files
------------

// File: rtl/mdu_scheduler.sv
// Multiply/divide unit controller for the E stage. Computes the full result
// at the start edge, holds it in pending registers for a fixed busy window,
// and commits it to HI/LO when that window ends. Also serves mfhi/mflo/mthi/
// mtlo and raises the stall request that holds MD-class instructions in D.
//
// Handshake: start is a single-cycle request qualified by MDU_Op in 1..4.
// It is accepted only in IDLE. MD_Stall is the back-pressure toward D and
// is asserted whenever D holds an MD-class op while an operation is
// starting or running, so start never arrives while busy.
module mdu_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDU_Op,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic        D_Is_MD,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDU_Result,
    output logic        MD_Stall,
    output logic        dbg_state_o
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   pend_hi_q, pend_hi_d;
    logic [31:0]   pend_lo_q, pend_lo_d;
    // Cleared for a divide by zero so the commit leaves HI/LO untouched.
    logic          pend_wr_q, pend_wr_d;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        divisor_nz;
    logic [31:0]        q_s, r_s, q_u, r_u;

    // Arithmetic datapath; divisor forced nonzero so the divider never sees 0.
    always_comb begin
        divisor_nz = (SrcB == 32'd0) ? 32'd1 : SrcB;
        prod_s     = $signed({{32{SrcA[31]}}, SrcA}) * $signed({{32{SrcB[31]}}, SrcB});
        prod_u     = {32'd0, SrcA} * {32'd0, SrcB};
        q_u        = SrcA / divisor_nz;
        r_u        = SrcA % divisor_nz;
        // The one signed overflow case is pinned explicitly.
        if (SrcA == 32'h8000_0000 && SrcB == 32'hFFFF_FFFF) begin
            q_s = 32'h8000_0000;
            r_s = 32'd0;
        end else begin
            q_s = $signed(SrcA) / $signed(divisor_nz);
            r_s = $signed(SrcA) % $signed(divisor_nz);
        end
    end

    // Next-state logic: accept ops in IDLE, count down and commit in BUSY.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (MDU_Op)
                        OP_MULT: begin
                            {pend_hi_d, pend_lo_d} = prod_s;
                            pend_wr_d = 1'b1;
                            cnt_d     = CW'(MULT_CYCLES);
                            state_d   = BUSY;
                        end
                        OP_MULTU: begin
                            {pend_hi_d, pend_lo_d} = prod_u;
                            pend_wr_d = 1'b1;
                            cnt_d     = CW'(MULT_CYCLES);
                            state_d   = BUSY;
                        end
                        OP_DIV: begin
                            pend_hi_d = r_s;
                            pend_lo_d = q_s;
                            pend_wr_d = (SrcB != 32'd0);
                            cnt_d     = CW'(DIV_CYCLES);
                            state_d   = BUSY;
                        end
                        OP_DIVU: begin
                            pend_hi_d = r_u;
                            pend_lo_d = q_u;
                            pend_wr_d = (SrcB != 32'd0);
                            cnt_d     = CW'(DIV_CYCLES);
                            state_d   = BUSY;
                        end
                        default: ;
                    endcase
                end else begin
                    if (MDU_Op == OP_MTHI) hi_d = SrcA;
                    if (MDU_Op == OP_MTLO) lo_d = SrcA;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and register update; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    // Outputs: reads see committed registers only, stall is purely combinational.
    always_comb begin
        busy        = (state_q == BUSY);
        dbg_state_o = state_q;
        HI          = hi_q;
        LO          = lo_q;
        MD_Stall    = D_Is_MD & (start | busy);
        case (MDU_Op)
            OP_MFHI: MDU_Result = hi_q;
            OP_MFLO: MDU_Result = lo_q;
            default: MDU_Result = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mdu_scheduler.sv
// Directed bench for mdu_scheduler: reset, mult, div/divu, divide by zero,
// stall generation, asynchronous reset mid-operation and back-to-back issue.
module tb_mdu_scheduler;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  MDU_Op;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        D_Is_MD;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDU_Result;
    logic        MD_Stall;
    logic        dbg_state_o;

    int checks;
    int errors;

    mdu_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .MDU_Op     (MDU_Op),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .D_Is_MD    (D_Is_MD),
        .busy       (busy),
        .HI         (HI),
        .LO         (LO),
        .MDU_Result (MDU_Result),
        .MD_Stall   (MD_Stall),
        .dbg_state_o(dbg_state_o)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol monitor: a start while busy is a hazard-unit violation.
    always @(negedge clk) begin
        if (!reset && start && busy) begin
            errors++;
            $display("FAIL protocol start_while_busy got start=1 busy=1 required start=0");
        end
    end

    // Advance one edge; inputs are changed and outputs sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        start  = 1'b0;
        MDU_Op = 4'd0;
        SrcA   = 32'd0;
        SrcB   = 32'd0;
    endtask

    // Present an op for one cycle, then return inputs to idle.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        MDU_Op = op;
        SrcA   = a;
        SrcB   = b;
        tick();
        drive_idle();
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        D_Is_MD = 1'b0;
        drive_idle();
        repeat (2) tick();
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || dbg_state_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got busy=%b HI=%h LO=%h st=%b required 0/0/0/0",
                     busy, HI, LO, dbg_state_o);
        end
    endtask

    task automatic test_mult();
        issue(4'd1, 32'hFFFF_FFFD, 32'd5);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (busy !== 1'b1 || HI !== 32'd0 || LO !== 32'd0) begin
                errors++;
                $display("FAIL mult_busy cyc%0d got busy=%b HI=%h LO=%h required 1/0/0",
                         i, busy, HI, LO);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFF1) begin
            errors++;
            $display("FAIL mult_result got busy=%b HI=%h LO=%h required 0/ffffffff/fffffff1",
                     busy, HI, LO);
        end
    endtask

    task automatic test_div();
        logic [31:0] exp_hi[3];
        logic [31:0] exp_lo[3];
        logic [3:0]  ops[3];
        logic [31:0] as[3];
        logic [31:0] bs[3];
        ops[0] = 4'd4; as[0] = 32'd7;          bs[0] = 32'd2;          exp_lo[0] = 32'd3;          exp_hi[0] = 32'd1;
        ops[1] = 4'd3; as[1] = 32'hFFFF_FFF9; bs[1] = 32'd2;          exp_lo[1] = 32'hFFFF_FFFD; exp_hi[1] = 32'hFFFF_FFFF;
        ops[2] = 4'd3; as[2] = 32'h8000_0000; bs[2] = 32'hFFFF_FFFF; exp_lo[2] = 32'h8000_0000; exp_hi[2] = 32'd0;
        for (int t = 0; t < 3; t++) begin
            issue(ops[t], as[t], bs[t]);
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL div%0d_busy cyc%0d got %b required 1", t, i, busy);
                end
                tick();
            end
            checks++;
            if (busy !== 1'b0 || HI !== exp_hi[t] || LO !== exp_lo[t]) begin
                errors++;
                $display("FAIL div%0d_result got busy=%b HI=%h LO=%h required 0/%h/%h",
                         t, busy, HI, LO, exp_hi[t], exp_lo[t]);
            end
        end
    endtask

    task automatic test_div_zero();
        MDU_Op = 4'd7; SrcA = 32'h11; tick();
        MDU_Op = 4'd8; SrcA = 32'h22; tick();
        drive_idle();
        checks++;
        if (HI !== 32'h11 || LO !== 32'h22) begin
            errors++;
            $display("FAIL mthi_mtlo got HI=%h LO=%h required 11/22", HI, LO);
        end
        issue(4'd3, 32'd5, 32'd0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL divzero_busy cyc%0d got %b required 1", i, busy);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0 || HI !== 32'h11 || LO !== 32'h22) begin
            errors++;
            $display("FAIL divzero_result got busy=%b HI=%h LO=%h required 0/11/22", busy, HI, LO);
        end
        MDU_Op = 4'd5; #1;
        checks++;
        if (MDU_Result !== 32'h11) begin
            errors++;
            $display("FAIL mfhi got %h required 11", MDU_Result);
        end
        MDU_Op = 4'd6; #1;
        checks++;
        if (MDU_Result !== 32'h22) begin
            errors++;
            $display("FAIL mflo got %h required 22", MDU_Result);
        end
        MDU_Op = 4'd0; #1;
        checks++;
        if (MDU_Result !== 32'd0) begin
            errors++;
            $display("FAIL result_none got %h required 0", MDU_Result);
        end
    endtask

    task automatic test_stall();
        for (int pass = 0; pass < 2; pass++) begin
            logic md;
            md = (pass == 0);
            D_Is_MD = md;
            #1;
            checks++;
            if (MD_Stall !== 1'b0) begin
                errors++;
                $display("FAIL stall%0d_pre got %b required 0", pass, MD_Stall);
            end
            start = 1'b1; MDU_Op = 4'd1; SrcA = 32'd2; SrcB = 32'd3;
            #1;
            checks++;
            if (MD_Stall !== md) begin
                errors++;
                $display("FAIL stall%0d_start got %b required %b", pass, MD_Stall, md);
            end
            tick();
            drive_idle();
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (MD_Stall !== md || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL stall%0d_busy cyc%0d got stall=%b busy=%b required %b/1",
                             pass, i, MD_Stall, busy, md);
                end
                tick();
            end
            checks++;
            if (MD_Stall !== 1'b0 || busy !== 1'b0 || LO !== 32'd6) begin
                errors++;
                $display("FAIL stall%0d_after got stall=%b busy=%b LO=%h required 0/0/6",
                         pass, MD_Stall, busy, LO);
            end
        end
        D_Is_MD = 1'b0;
    endtask

    task automatic test_async_reset();
        issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        tick();
        checks++;
        if (busy !== 1'b1 || HI !== 32'd0 || LO !== 32'd6) begin
            errors++;
            $display("FAIL arst_pre got busy=%b HI=%h LO=%h required 1/0/6", busy, HI, LO);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL arst_immediate got busy=%b HI=%h LO=%h required 0/0/0", busy, HI, LO);
        end
        #1;
        reset = 1'b0;
        repeat (8) tick();
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL arst_after got busy=%b HI=%h LO=%h required 0/0/0", busy, HI, LO);
        end
    endtask

    task automatic test_back_to_back();
        issue(4'd5, 32'd1, 32'd1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_op_start got busy=%b required 0", busy);
        end
        issue(4'd4, 32'd9, 32'd4);
        repeat (10) tick();
        checks++;
        if (busy !== 1'b0 || HI !== 32'd1 || LO !== 32'd2) begin
            errors++;
            $display("FAIL b2b_div got busy=%b HI=%h LO=%h required 0/1/2", busy, HI, LO);
        end
        issue(4'd1, 32'd3, 32'd4);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept got busy=%b required 1", busy);
        end
        MDU_Op = 4'd7; SrcA = 32'hDEAD;
        tick();
        drive_idle();
        checks++;
        if (HI !== 32'd1) begin
            errors++;
            $display("FAIL mthi_busy got HI=%h required 1", HI);
        end
        repeat (4) tick();
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd12) begin
            errors++;
            $display("FAIL b2b_mult got busy=%b HI=%h LO=%h required 0/0/c", busy, HI, LO);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_stall();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
